mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage: one op at a time, aligned 32-bit data-memory requests, sized/extended writeback.
// Latency: 1 cycle for pass-through and fault ops, longer for stores and loads; request held until mem_gnt, result held until out_ready.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funcMem,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        reg_write_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        wr_en;
  } op_t;

  state_t      state, state_nxt;
  op_t         op_q, op_d;
  logic [31:0] wb_data_q;
  logic        wb_we_q;
  logic        fault_q;

  logic        accept;
  logic        mem_op;
  logic        bad_func;
  logic        misalign;
  logic        acc_fault;
  logic [31:0] lane;
  logic [31:0] load_val;

  assign accept    = (state == IDLE) && in_valid;
  assign mem_op    = is_load | is_store;
  assign acc_fault = mem_op && (bad_func || misalign);

  // Unsigned variants exist only for loads; codes 011 and 11x are never legal.
  always_comb begin
    bad_func = 1'b0;
    misalign = 1'b0;
    case (funcMem)
      3'b000:  misalign = 1'b0;
      3'b001:  misalign = addr[0];
      3'b010:  misalign = |addr[1:0];
      3'b100:  bad_func = is_store;
      3'b101:  begin
        bad_func = is_store;
        misalign = addr[0];
      end
      default: bad_func = 1'b1;
    endcase
  end

  always_comb begin
    op_d.is_store = is_store;
    op_d.func     = funcMem;
    op_d.addr     = addr;
    op_d.sdata    = store_data;
    op_d.rd       = rd;
    op_d.wr_en    = reg_write_in && (rd != 5'd0);
  end

  // Halfword loads are aligned, so a byte-granular shift selects either lane size.
  assign lane = mem_rdata >> {op_q.addr[1:0], 3'b000};

  always_comb begin
    case (op_q.func)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (!mem_op || acc_fault) ? DONE : REQ;
      REQ:  if (mem_gnt) state_nxt = op_q.is_store ? DONE : WAIT;
      WAIT: if (mem_rvalid) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      wb_data_q <= 32'h0;
      wb_we_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else if (accept) begin
      op_q      <= op_d;
      wb_data_q <= mem_op ? 32'h0 : addr;
      wb_we_q   <= !mem_op && op_d.wr_en;
      fault_q   <= acc_fault;
    end else if (state == WAIT && mem_rvalid) begin
      wb_data_q <= load_val;
      wb_we_q   <= op_q.wr_en;
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    mem_req   = (state == REQ);
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    if (state == REQ) begin
      mem_addr = {op_q.addr[31:2], 2'b00};
      mem_we   = op_q.is_store;
      if (op_q.is_store) begin
        case (op_q.func[1:0])
          2'b00: begin
            mem_be    = 4'b0001 << op_q.addr[1:0];
            mem_wdata = {4{op_q.sdata[7:0]}};
          end
          2'b01: begin
            mem_be    = 4'b0011 << op_q.addr[1:0];
            mem_wdata = {2{op_q.sdata[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = op_q.sdata;
          end
        endcase
      end else begin
        mem_be = 4'b1111;
      end
    end
    out_valid = (state == DONE);
    wb_rd     = out_valid ? op_q.rd   : 5'd0;
    wb_data   = out_valid ? wb_data_q : 32'h0;
    wb_we     = out_valid && wb_we_q;
    fault     = out_valid && fault_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reference model of the access rules plus hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funcMem = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd = 5'd0;
  logic        reg_write_in = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        fault;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funcMem(funcMem),
    .addr(addr), .store_data(store_data), .rd(rd), .reg_write_in(reg_write_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we), .fault(fault)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected behaviour of the op in flight
  logic        active = 1'b0;
  logic        e_mem, e_st, e_we, e_fault;
  logic [3:0]  e_be;
  logic [31:0] e_wd, e_data, e_addr;
  logic [4:0]  e_rd;

  // Values seen on the DUT during the last op
  logic        seen_req = 1'b0;
  logic        o_mwe, o_wbwe, o_fault;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wd, o_data;

  function automatic void model(
    input  logic        ld, st,
    input  logic [2:0]  f,
    input  logic [31:0] a, sd, rdat,
    input  logic [4:0]  r,
    input  logic        rwe,
    output logic        m_mem,
    output logic [3:0]  m_be,
    output logic [31:0] m_wd,
    output logic [31:0] m_data,
    output logic        m_we,
    output logic        m_fault);
    int n, off;
    logic legal, sgn;
    logic [31:0] v;
    n = 1; legal = 1'b1; sgn = 1'b1;
    case (f)
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd4: begin n = 1; legal = !st; sgn = 1'b0; end
      3'd5: begin n = 2; legal = !st; sgn = 1'b0; end
      default: legal = 1'b0;
    endcase
    off = int'(a % 4);
    m_fault = (ld || st) && (!legal || (off % n) != 0);
    m_mem   = (ld || st) && !m_fault;
    m_be    = st ? 4'(((1 << n) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) m_wd[8*i +: 8] = sd[8*(i % n) +: 8];
    v = 32'h0;
    for (int k = 0; k < n && off + k < 4; k++) v[8*k +: 8] = rdat[8*(off+k) +: 8];
    if (sgn && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    if (!ld && !st) begin
      m_data = a;
      m_we   = rwe && (r != 0);
    end else if (ld && m_mem) begin
      m_data = v;
      m_we   = rwe && (r != 0);
    end else begin
      m_data = 32'h0;
      m_we   = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && active) begin
      if (!e_mem) chk("no_mem_req", mem_req, 1'b0);
      if (mem_req) begin
        seen_req = 1'b1;
        o_addr = mem_addr; o_be = mem_be; o_wd = mem_wdata; o_mwe = mem_we;
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", mem_we, e_st);
        chk("mem_be", mem_be, e_be);
        if (e_st) chk("mem_wdata", mem_wdata, e_wd);
      end else begin
        chk("mem_be_idle", mem_be, 4'b0000);
      end
      if (mem_req || out_valid) chk("in_ready_busy", in_ready, 1'b0);
      if (out_valid) begin
        chk("wb_rd", wb_rd, e_rd);
        chk("wb_data", wb_data, e_data);
        chk("wb_we", wb_we, e_we);
        chk("fault", fault, e_fault);
      end
    end
  end

  task automatic run_op(input logic ld, st, input logic [2:0] f,
                        input logic [31:0] a, sd, input logic [4:0] r, input logic rwe,
                        input logic [31:0] rdat, input int gw, rvd, rdyd);
    int n;
    model(ld, st, f, a, sd, rdat, r, rwe, e_mem, e_be, e_wd, e_data, e_we, e_fault);
    e_st = st; e_addr = {a[31:2], 2'b00}; e_rd = r;
    seen_req = 1'b0; active = 1'b1;
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; is_load = ld; is_store = st; funcMem = f;
    addr = a; store_data = sd; rd = r; reg_write_in = rwe;
    @(posedge clk); #1;
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = 32'h0; store_data = 32'h0;
    if (e_mem) begin
      repeat (gw) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (ld) begin
        chk("wait_no_valid", out_valid, 1'b0);
        repeat (rvd) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1; mem_rdata = rdat;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
      end
    end
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("out_valid_seen", out_valid, 1'b1);
    chk("latency_extra", n, 0);
    o_data = wb_data; o_wbwe = wb_we; o_fault = fault;
    repeat (rdyd) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 1'b0);
    chk("post_hs_ready", in_ready, 1'b1);
    active = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_be", mem_be, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rel_in_ready", in_ready, 1'b1);

    // LB: sign-extend byte 3, grant on 2nd REQ cycle, return next cycle
    run_op(1, 0, 3'b000, 32'h1003, 32'h0, 5'd5, 1, 32'h80FF_FF7F, 1, 0, 0);
    chk("lb_mem_addr", o_addr, 32'h1000);
    chk("lb_wb_data", o_data, 32'hFFFF_FF80);
    chk("lb_wb_we", o_wbwe, 1'b1);
    // LHU / LH upper halfword
    run_op(1, 0, 3'b101, 32'h2002, 32'h0, 5'd6, 1, 32'hBEEF_1234, 0, 1, 0);
    chk("lhu_wb_data", o_data, 32'h0000_BEEF);
    run_op(1, 0, 3'b001, 32'h2002, 32'h0, 5'd6, 1, 32'hBEEF_1234, 2, 0, 0);
    chk("lh_wb_data", o_data, 32'hFFFF_BEEF);
    // SB lane 1
    run_op(0, 1, 3'b000, 32'h3001, 32'h0000_00AB, 5'd0, 0, 32'h0, 0, 0, 0);
    chk("sb_mem_be", o_be, 4'b0010);
    chk("sb_mem_wdata", o_wd, 32'hABAB_ABAB);
    chk("sb_mem_we", o_mwe, 1'b1);
    chk("sb_wb_we", o_wbwe, 1'b0);
    // Misaligned SW faults without a request
    run_op(0, 1, 3'b010, 32'h4002, 32'h1111_2222, 5'd3, 1, 32'h0, 0, 0, 0);
    chk("sw_mis_req", seen_req, 1'b0);
    chk("sw_mis_fault", o_fault, 1'b1);
    // Pass-through: rd=0 suppresses write; rd!=0 with 3-cycle backpressure
    run_op(0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd0, 1, 32'h0, 0, 0, 0);
    chk("pt_rd0_we", o_wbwe, 1'b0);
    chk("pt_rd0_data", o_data, 32'h1234_5678);
    run_op(0, 0, 3'b010, 32'hCAFE_0001, 32'h0, 5'd7, 1, 32'h0, 0, 0, 3);
    chk("pt_data", o_data, 32'hCAFE_0001);
    // LW with waits and held output
    run_op(1, 0, 3'b010, 32'h5000, 32'h0, 5'd9, 1, 32'hCAFE_F00D, 2, 2, 2);
    chk("lw_wb_data", o_data, 32'hCAFE_F00D);
    // SH upper half
    run_op(0, 1, 3'b001, 32'h6002, 32'h1234_ABCD, 5'd1, 1, 32'h0, 1, 0, 1);
    chk("sh_mem_be", o_be, 4'b1100);
    chk("sh_mem_wdata", o_wd, 32'hABCD_ABCD);
    // SW aligned
    run_op(0, 1, 3'b010, 32'h6004, 32'h89AB_CDEF, 5'd1, 1, 32'h0, 0, 0, 0);
    chk("sw_mem_be", o_be, 4'b1111);
    // LBU byte 1 zero-extended
    run_op(1, 0, 3'b100, 32'h7001, 32'h0, 5'd2, 1, 32'h1122_33C4, 0, 0, 0);
    chk("lbu_wb_data", o_data, 32'h0000_0033);
    // Illegal codes and misaligned halfword
    run_op(1, 0, 3'b011, 32'h7000, 32'h0, 5'd2, 1, 32'h0, 0, 0, 0);
    chk("ill_011_fault", o_fault, 1'b1);
    run_op(0, 1, 3'b100, 32'h7000, 32'h0, 5'd2, 1, 32'h0, 0, 0, 0);
    chk("sbu_fault", o_fault, 1'b1);
    run_op(1, 0, 3'b110, 32'h7000, 32'h0, 5'd2, 1, 32'h0, 0, 0, 0);
    run_op(1, 0, 3'b001, 32'h8001, 32'h0, 5'd2, 1, 32'h0, 0, 0, 0);
    chk("lh_mis_req", seen_req, 1'b0);
    // Load without writeback enable
    run_op(1, 0, 3'b000, 32'h8002, 32'h0, 5'd4, 0, 32'h00FF_0000, 0, 0, 0);
    chk("lb_nowe", o_wbwe, 1'b0);

    // Reset while waiting for load data
    in_valid = 1'b1; is_load = 1'b1; funcMem = 3'b010; addr = 32'h9000; rd = 5'd8; reg_write_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; is_load = 1'b0;
    chk("rst_tst_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rst_tst_wait_req", mem_req, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_wait_mem_req", mem_req, 1'b0);
    chk("rst_wait_out_valid", out_valid, 1'b0);
    chk("rst_wait_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rvalid_valid", out_valid, 1'b0);
    chk("late_rvalid_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("late_rvalid_valid2", out_valid, 1'b0);
    chk("late_rvalid_wb", wb_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
